// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - bit-serial frame receiver with trailing parity check
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 IN_VALID,
  input  logic                 IN_BIT,
  output logic                 BUSY,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 PAR_CALC,
  output logic                 PAR_ERR,
  output logic                 DONE
);

  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 par_calc_q, par_calc_d;
  logic                 par_err_q, par_err_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  // Next-state logic: START always wins and restarts the frame; otherwise
  // only IN_VALID cycles advance the frame.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    par_calc_d = par_calc_q;
    par_err_d  = par_err_q;
    done_d     = 1'b0;
    if (START) begin
      state_d = S_DATA;
      count_d = '0;
      shift_d = '0;
      acc_d   = ODD;
    end else if (IN_VALID) begin
      case (state_q)
        S_DATA: begin
          // Place the bit at its LSB-first position; unreceived bits stay 0.
          for (int i = 0; i < DATA_BITS; i++) begin
            if (count_q == CW'(i)) shift_d[i] = IN_BIT;
          end
          acc_d   = acc_q ^ IN_BIT;
          count_d = count_q + 1'b1;
          if (count_q == CW'(DATA_BITS - 1)) state_d = S_PAR;
        end
        S_PAR: begin
          par_calc_d = acc_q;
          par_err_d  = acc_q ^ IN_BIT;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
        default: ;
      endcase
    end
    // BUSY is registered from the next state so it falls together with DONE.
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      par_calc_q <= 1'b0;
      par_err_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      par_calc_q <= par_calc_d;
      par_err_q  <= par_err_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign BUSY     = busy_q;
  assign DATA_OUT = shift_q;
  assign PAR_CALC = par_calc_q;
  assign PAR_ERR  = par_err_q;
  assign DONE     = done_q;

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Bit-serial frame receiver that accumulates the XOR of incoming data bits and checks the result against a trailing parity bit. It sits downstream of the two-input XOR stage: each valid bit is folded into a running parity register (parity_next = parity ^ IN_BIT). The block reassembles the frame word and reports the computed parity and a mismatch flag. It is used wherever a single-wire data stream needs frame-level integrity checking before it reaches parallel logic.

## Interface

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal range 1..32)
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- START  input  1  begin a new frame; accepted in any state
- IN_VALID  input  1  IN_BIT is valid this cycle
- IN_BIT  input  1  serial data, LSB first, followed by the parity bit
- BUSY  output  1  high while a frame is in progress (DATA or PAR state)
- DATA_OUT  output  DATA_BITS  reassembled frame word, held after DONE
- PAR_CALC  output  1  expected parity bit for the last completed frame
- PAR_ERR  output  1  received parity != PAR_CALC for the last completed frame
- DONE  output  1  one-cycle pulse when a frame completes

One clock domain. Reset is asynchronous and active-low.

## Operation

- States: IDLE, DATA, PAR.
- IDLE: on START -> DATA. Clear the bit counter and the shift register, and load the accumulator with ODD.
- DATA: on each IN_VALID cycle:
  - shift IN_BIT into DATA_OUT at position count (LSB first);
  - acc <= acc ^ IN_BIT;
  - count++.
  - After the DATA_BITS-th valid bit -> PAR.
- PAR: on the first IN_VALID cycle:
  - PAR_CALC <= acc;
  - PAR_ERR <= acc ^ IN_BIT;
  - DONE pulses;
  - state -> IDLE.
- Cycles with IN_VALID=0 are ignored in all states. Gaps of any length are allowed.
- IN_VALID in IDLE without START is ignored, and no state changes.
- START priority: START in DATA or PAR aborts the current frame and restarts it (same actions as the START from IDLE). No DONE is produced for the aborted frame, and PAR_CALC/PAR_ERR keep their previous values.
- On the START cycle itself, IN_BIT is not sampled, even if IN_VALID=1. The first data bit is the first IN_VALID cycle after START.
- Counter width: clog2(DATA_BITS+1). The counter never wraps; it is cleared on START.
- DATA_OUT bits not yet received read 0 during DATA. DATA_OUT is stable from DONE until the next START.

## Timing

- All outputs are registered.
- Reset values: BUSY=0, DATA_OUT=0, PAR_CALC=0, PAR_ERR=0, DONE=0, state=IDLE.
- Reset mid-frame returns the block to IDLE immediately (asynchronous). No DONE is produced.
- BUSY rises the cycle after START is sampled. It falls in the same cycle DONE rises.
- DONE is high for exactly one cycle: the cycle after the parity bit is sampled.
- PAR_CALC, PAR_ERR and the final DATA_OUT are valid in the DONE cycle and hold afterwards.
- Minimum frame length: 1 START cycle + DATA_BITS + 1 valid cycles. DONE follows one cycle later.
- Back-to-back frames: START may be asserted in the DONE cycle. That START is accepted, and BUSY is high on the next cycle.

## Test plan

- Clean even frame (DATA_BITS=8, ODD=0): START, then bits 1,0,1,0,0,1,0,1 (0xA5), then parity 0 -> DONE one cycle, DATA_OUT=0xA5, PAR_CALC=0, PAR_ERR=0, BUSY=0 after DONE.
- Parity error: frame 0x07 with parity bit 0 -> DONE, DATA_OUT=0x07, PAR_CALC=1, PAR_ERR=1.
- Gapped input: frame 0x3C with random 0-3 cycle IN_VALID gaps, plus IN_VALID=1 on the START cycle (that bit must be dropped) -> DATA_OUT=0x3C, PAR_CALC=0, PAR_ERR=0.
- Abort: START, 4 bits, then START again, then full frame 0xFF with parity 0 -> exactly one DONE, DATA_OUT=0xFF, PAR_ERR=0.
- Async reset: RST_N low mid-DATA between clock edges -> all outputs 0 immediately. The next START and frame 0x01 with parity 1 give PAR_ERR=0.
- Odd sense (ODD=1): frame 0x00 with parity 1 -> PAR_CALC=1, PAR_ERR=0. Same frame with parity 0 -> PAR_ERR=1.
